mat_mul_sequencer: RTL and testbench

Command-driven sequencer for the transform datapath. It replaces hand-driven address and enable stimulus with a single command handshake. It drives BRAM row addresses, `load_en`/`push_en` into `matrix_ctrl`, and `mul_en`/`mul_type`/`matrix_mode` into `matrix_mul`. It streams vertex transforms one per cycle and reports when each result is valid.

---
 rtl/mat_mul_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_mat_mul_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mul_sequencer.sv
// Command-driven sequencer for matrix_ctrl / matrix_mul: LOAD, VERT and MATMUL commands.
// Optional stack push before LOAD is compiled in with `define MAT_SEQ_PUSH_EN.
module mat_mul_sequencer #(
  parameter int MUL_LAT    = 4,
  parameter int ROW_STRIDE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_mode,
  input  logic        cmd_push,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_count,
  output logic [31:0] bram_addr,
  output logic        load_en,
  output logic        push_en,
  output logic        mul_en,
  output logic        mul_type,
  output logic        matrix_mode,
  output logic        vert_valid,
  output logic [15:0] vert_index,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_LOAD, S_VERT, S_MAT, S_DRAIN, S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] base_reg, base_next;
  logic [15:0] count_reg, count_next;
  logic [15:0] idx_reg, idx_next;
  logic        err_flag_reg, err_flag_next;
  logic        mode_next;
  logic        push_req;
  logic        pipe_busy;

  logic        load_en_next, push_en_next, mul_en_next, mul_type_next;
  logic        done_next, err_next;
  logic [31:0] bram_addr_next;

`ifdef MAT_SEQ_PUSH_EN
  assign push_req = cmd_push;
`else
  logic unused_cmd_push;
  assign unused_cmd_push = cmd_push;
  assign push_req        = 1'b0;
`endif

  assign cmd_ready = (state_reg == S_IDLE);
  assign busy      = (state_reg != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      base_reg     <= 32'd0;
      count_reg    <= 16'd0;
      idx_reg      <= 16'd0;
      err_flag_reg <= 1'b0;
      matrix_mode  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      base_reg     <= base_next;
      count_reg    <= count_next;
      idx_reg      <= idx_next;
      err_flag_reg <= err_flag_next;
      matrix_mode  <= mode_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    base_next     = base_reg;
    count_next    = count_reg;
    idx_next      = idx_reg;
    err_flag_next = err_flag_reg;
    mode_next     = matrix_mode;
    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          base_next     = cmd_addr;
          count_next    = cmd_count;
          mode_next     = cmd_mode;
          err_flag_next = (cmd_op == 2'b11);
          idx_next      = 16'd0;
          case (cmd_op)
            2'b00:   state_next = push_req ? S_PUSH : S_LOAD;
            2'b01:   state_next = (cmd_count == 16'd0) ? S_DONE : S_VERT;
            2'b10:   state_next = S_MAT;
            default: state_next = S_DONE;
          endcase
        end
      end
      S_PUSH: begin
        state_next = S_LOAD;
        idx_next   = 16'd0;
      end
      S_LOAD: begin
        if (idx_reg == 16'd3) state_next = S_DONE;
        else                  idx_next   = idx_reg + 16'd1;
      end
      S_VERT: begin
        if (idx_reg == count_reg - 16'd1) state_next = S_DRAIN;
        else                              idx_next   = idx_reg + 16'd1;
      end
      S_MAT:   state_next = S_DRAIN;
      S_DRAIN: if (!pipe_busy) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they land in registers aligned with the state.
  always_comb begin
    load_en_next   = (state_next == S_LOAD);
    push_en_next   = (state_next == S_PUSH);
    mul_en_next    = (state_next == S_VERT) || (state_next == S_MAT);
    mul_type_next  = (state_next == S_MAT);
    done_next      = (state_next == S_DONE);
    err_next       = (state_next == S_DONE) && err_flag_next;
    bram_addr_next = 32'd0;
    if (load_en_next || mul_en_next)
      bram_addr_next = base_next + 32'(idx_next) * 32'(ROW_STRIDE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_en   <= 1'b0;
      push_en   <= 1'b0;
      mul_en    <= 1'b0;
      mul_type  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      bram_addr <= 32'd0;
    end else begin
      load_en   <= load_en_next;
      push_en   <= push_en_next;
      mul_en    <= mul_en_next;
      mul_type  <= mul_type_next;
      done      <= done_next;
      err       <= err_next;
      bram_addr <= bram_addr_next;
    end
  end

  // Valid pipe mirrors the multiplier latency; MAT entries occupy it but never report.
  logic        pipe_valid [MUL_LAT];
  logic        pipe_vert  [MUL_LAT];
  logic [15:0] pipe_idx   [MUL_LAT];

  genvar gi;
  generate
    for (gi = 0; gi < MUL_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            pipe_valid[0] <= 1'b0;
            pipe_vert[0]  <= 1'b0;
            pipe_idx[0]   <= 16'd0;
          end else begin
            pipe_valid[0] <= mul_en;
            pipe_vert[0]  <= mul_en & ~mul_type;
            pipe_idx[0]   <= idx_reg;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            pipe_valid[gi] <= 1'b0;
            pipe_vert[gi]  <= 1'b0;
            pipe_idx[gi]   <= 16'd0;
          end else begin
            pipe_valid[gi] <= pipe_valid[gi-1];
            pipe_vert[gi]  <= pipe_vert[gi-1];
            pipe_idx[gi]   <= pipe_idx[gi-1];
          end
        end
      end
    end
  endgenerate

  // The last stage drains on the coming edge, so only earlier stages hold DRAIN open.
  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k < MUL_LAT - 1; k++)
      pipe_busy = pipe_busy | pipe_valid[k];
  end

  assign vert_valid = pipe_valid[MUL_LAT-1] & pipe_vert[MUL_LAT-1];
  assign vert_index = vert_valid ? pipe_idx[MUL_LAT-1] : 16'd0;

endmodule

// File: tb/tb_mat_mul_sequencer.sv
// Self-checking bench for mat_mul_sequencer: per-command timeline model built from offsets after accept.
// Honours MAT_SEQ_PUSH_EN when deciding whether a LOAD with push inserts the push cycle.
module tb_mat_mul_sequencer;
  localparam int L = 4;
  localparam int S = 16;
`ifdef MAT_SEQ_PUSH_EN
  localparam bit PUSH_ON = 1'b1;
`else
  localparam bit PUSH_ON = 1'b0;
`endif

  logic        clk, rst, cmd_valid, cmd_ready, cmd_mode, cmd_push;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, bram_addr;
  logic [15:0] cmd_count, vert_index;
  logic        load_en, push_en, mul_en, mul_type, matrix_mode;
  logic        vert_valid, busy, done, err;

  mat_mul_sequencer #(.MUL_LAT(L), .ROW_STRIDE(S)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_push(cmd_push),
    .cmd_addr(cmd_addr), .cmd_count(cmd_count), .bram_addr(bram_addr),
    .load_en(load_en), .push_en(push_en), .mul_en(mul_en), .mul_type(mul_type),
    .matrix_mode(matrix_mode), .vert_valid(vert_valid), .vert_index(vert_index),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Expected outputs indexed by cycle offset after the accepting edge.
  logic        e_load [256];
  logic        e_push [256];
  logic        e_mul  [256];
  logic        e_type [256];
  logic        e_vv   [256];
  logic        e_done [256];
  logic        e_err  [256];
  logic [31:0] e_addr [256];
  logic [15:0] e_idx  [256];
  int          e_len;

  task automatic build(input logic [1:0] op, input logic push, input logic [31:0] addr,
                       input logic [15:0] count);
    int p;
    for (int k = 0; k < 256; k++) begin
      e_load[k] = 0; e_push[k] = 0; e_mul[k] = 0; e_type[k] = 0; e_vv[k] = 0;
      e_done[k] = 0; e_err[k] = 0; e_addr[k] = 0; e_idx[k] = 0;
    end
    case (op)
      2'b00: begin
        p = (PUSH_ON && push) ? 1 : 0;
        if (p == 1) e_push[1] = 1;
        for (int r = 0; r < 4; r++) begin
          e_load[1+p+r] = 1;
          e_addr[1+p+r] = addr + 32'(r * S);
        end
        e_len = 5 + p;
      end
      2'b01: begin
        if (count == 0) e_len = 1;
        else begin
          for (int v = 0; v < int'(count); v++) begin
            e_mul[1+v]  = 1;
            e_addr[1+v] = addr + 32'(v * S);
            e_vv[1+v+L] = 1;
            e_idx[1+v+L] = 16'(v);
          end
          e_len = int'(count) + L + 1;
        end
      end
      2'b10: begin
        e_mul[1] = 1; e_type[1] = 1; e_addr[1] = addr;
        e_len = 2 + L;
      end
      default: begin
        e_len = 1;
        e_err[1] = 1;
      end
    endcase
    e_done[e_len] = 1;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic mode, input logic push,
                         input logic [31:0] addr, input logic [15:0] count,
                         input bit hold, input string name);
    build(op, push, addr, count);
    @(negedge clk);
    cmd_op = op; cmd_mode = mode; cmd_push = push; cmd_addr = addr; cmd_count = count;
    cmd_valid = 1'b1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL %s ready_before_accept got=%b exp=1", name, cmd_ready);
    end
    @(posedge clk);
    for (int k = 1; k <= e_len; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) cmd_valid = 1'b0;
      tests++;
      if (load_en !== e_load[k]) begin
        fails++; $display("FAIL %s k=%0d load_en got=%b exp=%b", name, k, load_en, e_load[k]);
      end
      tests++;
      if (push_en !== e_push[k]) begin
        fails++; $display("FAIL %s k=%0d push_en got=%b exp=%b", name, k, push_en, e_push[k]);
      end
      tests++;
      if (mul_en !== e_mul[k]) begin
        fails++; $display("FAIL %s k=%0d mul_en got=%b exp=%b", name, k, mul_en, e_mul[k]);
      end
      if (e_mul[k]) begin
        tests++;
        if (mul_type !== e_type[k]) begin
          fails++; $display("FAIL %s k=%0d mul_type got=%b exp=%b", name, k, mul_type, e_type[k]);
        end
      end
      if (e_mul[k] || e_load[k]) begin
        tests++;
        if (bram_addr !== e_addr[k]) begin
          fails++; $display("FAIL %s k=%0d bram_addr got=%h exp=%h", name, k, bram_addr, e_addr[k]);
        end
      end
      tests++;
      if (vert_valid !== e_vv[k]) begin
        fails++; $display("FAIL %s k=%0d vert_valid got=%b exp=%b", name, k, vert_valid, e_vv[k]);
      end
      if (e_vv[k]) begin
        tests++;
        if (vert_index !== e_idx[k]) begin
          fails++; $display("FAIL %s k=%0d vert_index got=%0d exp=%0d", name, k, vert_index, e_idx[k]);
        end
      end
      tests++;
      if (done !== e_done[k]) begin
        fails++; $display("FAIL %s k=%0d done got=%b exp=%b", name, k, done, e_done[k]);
      end
      if (e_done[k]) begin
        tests++;
        if (err !== e_err[k]) begin
          fails++; $display("FAIL %s k=%0d err got=%b exp=%b", name, k, err, e_err[k]);
        end
      end
      tests++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
        fails++; $display("FAIL %s k=%0d busy/ready got=%b/%b exp=1/0", name, k, busy, cmd_ready);
      end
      tests++;
      if (matrix_mode !== mode) begin
        fails++; $display("FAIL %s k=%0d matrix_mode got=%b exp=%b", name, k, matrix_mode, mode);
      end
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || vert_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s after_done done/busy/ready/vv got=%b/%b/%b/%b exp=0/0/1/0",
               name, done, busy, cmd_ready, vert_valid);
    end
    $display("[TB] %s op=%0d mode=%0d push=%0d addr=%h count=%0d done_at=N+%0d",
             name, op, mode, push, addr, count, e_len);
  endtask

  task automatic test_reset;
    #12;
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || bram_addr !== 32'd0 || load_en !== 1'b0 ||
        push_en !== 1'b0 || mul_en !== 1'b0 || mul_type !== 1'b0 || matrix_mode !== 1'b0 ||
        vert_valid !== 1'b0 || vert_index !== 16'd0 || done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state ready=%b busy=%b addr=%h strobes=%b%b%b done=%b err=%b exp ready=1 rest=0",
               cmd_ready, busy, bram_addr, load_en, push_en, mul_en, done, err);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_load;
    run_cmd(2'b00, 1'b0, 1'b0, 32'h0, 16'd0, 1'b0, "load");
  endtask

  task automatic test_load_push;
    run_cmd(2'b00, 1'b1, 1'b1, 32'h40, 16'd0, 1'b0, "load_push");
  endtask

  task automatic test_vert;
    run_cmd(2'b01, 1'b0, 1'b0, 32'h100, 16'd3, 1'b0, "vert3");
  endtask

  task automatic test_zero_and_reserved;
    run_cmd(2'b01, 1'b0, 1'b0, 32'h300, 16'd0, 1'b0, "vert_zero");
    run_cmd(2'b11, 1'b1, 1'b0, 32'h300, 16'd5, 1'b0, "reserved");
  endtask

  task automatic test_matmul_hold;
    bit seen;
    run_cmd(2'b10, 1'b1, 1'b0, 32'h200, 16'd0, 1'b1, "matmul_hold");
    @(negedge clk);
    tests++;
    if (mul_en !== 1'b1 || mul_type !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL held_accept mul_en/mul_type/busy got=%b/%b/%b exp=1/1/1", mul_en, mul_type, busy);
    end
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL held_done got=timeout exp=done");
    end
    @(negedge clk);
    $display("[TB] matmul_hold second accept observed");
  endtask

  task automatic test_vert_random;
    logic [31:0] a;
    logic [15:0] c;
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 32'hFFFF_FFE0 : ($urandom & 32'hFFFF_FFF0);
      c = 16'($urandom_range(1, 12));
      run_cmd(2'b01, 1'($urandom_range(0, 1)), 1'b0, a, c, 1'b0, "vert_rand");
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom & 32'hFFFF_FFF0, 16'($urandom_range(0, 6)), 1'b0, "b2b");
    end
  endtask

  task automatic test_reset_mid_vert;
    @(negedge clk);
    cmd_op = 2'b01; cmd_mode = 1'b1; cmd_push = 1'b0; cmd_addr = 32'h500; cmd_count = 16'd10;
    cmd_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || mul_en !== 1'b0 || bram_addr !== 32'd0 ||
        matrix_mode !== 1'b0 || vert_valid !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset ready=%b busy=%b mul_en=%b addr=%h mode=%b vv=%b done=%b exp ready=1 rest=0",
               cmd_ready, busy, mul_en, bram_addr, matrix_mode, vert_valid, done);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || vert_valid !== 1'b0 || mul_en !== 1'b0 || cmd_ready !== 1'b1) begin
        fails++;
        $display("FAIL post_reset k=%0d done/vv/mul_en/ready got=%b/%b/%b/%b exp=0/0/0/1",
                 k, done, vert_valid, mul_en, cmd_ready);
      end
    end
    $display("[TB] reset_mid_vert aborted cleanly checked");
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_mode = 1'b0; cmd_push = 1'b0;
    cmd_addr = 32'd0; cmd_count = 16'd0;
    test_reset();
    test_load();
    test_load_push();
    test_vert();
    test_zero_and_reserved();
    test_matmul_hold();
    test_vert_random();
    test_back_to_back();
    test_reset_mid_vert();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
